// File: rtl/axis_i2c_target.sv
// I2C target endpoint bridging bus writes to m_axis and bus reads from s_axis.
// Optional glitch filter on SCL/SDA: define AXIS_I2C_TARGET_GLITCH_FILTER_EN.
`timescale 1ns/1ps
module axis_i2c_target #(
  parameter logic [6:0]  TARGET_ADDR = 7'h50,
  parameter int unsigned FILTER_LEN  = 3,
  parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
  input  logic       clk_i,
  input  logic       arstn_i,
  input  logic       en_i,
  input  logic       i2c_scl_i,
  inout  wire        i2c_sda_io,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic       busy_o
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StAddr    = 3'd1;
  localparam logic [2:0] StAddrAck = 3'd2;
  localparam logic [2:0] StWrData  = 3'd3;
  localparam logic [2:0] StWrAck   = 3'd4;
  localparam logic [2:0] StRdData  = 3'd5;
  localparam logic [2:0] StRdAck   = 3'd6;
  localparam logic [2:0] StWait    = 3'd7;

  logic [1:0] scl_sync, sda_sync;
  logic       scl, sda, scl_q, sda_q;
  logic       start_ev, stop_ev, rise_ev, fall_ev;

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], i2c_scl_i};
      sda_sync <= {sda_sync[0], i2c_sda_io};
    end
  end

`ifdef AXIS_I2C_TARGET_GLITCH_FILTER_EN
  logic [3:0] scl_cnt, sda_cnt;
  logic       scl_f, sda_f;

  // Output follows the input only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      scl_f   <= 1'b1;
      sda_f   <= 1'b1;
      scl_cnt <= '0;
      sda_cnt <= '0;
    end else begin
      if (scl_sync[1] == scl_f) begin
        scl_cnt <= '0;
      end else if (scl_cnt == 4'(FILTER_LEN - 1)) begin
        scl_f   <= scl_sync[1];
        scl_cnt <= '0;
      end else begin
        scl_cnt <= scl_cnt + 4'd1;
      end
      if (sda_sync[1] == sda_f) begin
        sda_cnt <= '0;
      end else if (sda_cnt == 4'(FILTER_LEN - 1)) begin
        sda_f   <= sda_sync[1];
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_cnt + 4'd1;
      end
    end
  end

  assign scl = scl_f;
  assign sda = sda_f;
`else
  assign scl = scl_sync[1];
  assign sda = sda_sync[1];
`endif

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl;
      sda_q <= sda;
    end
  end

  assign start_ev = scl & scl_q & sda_q & ~sda;
  assign stop_ev  = scl & scl_q & ~sda_q & sda;
  assign rise_ev  = scl & ~scl_q;
  assign fall_ev  = ~scl & scl_q;

  logic [2:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [6:0] shreg_q, shreg_d;
  logic [6:0] tx_q, tx_d;
  logic       rw_q, rw_d;
  logic       phase_q, phase_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] m_data_q, m_data_d;
  logic       m_valid_q, m_valid_d;
  logic       s_ready_q, s_ready_d;
  logic       busy_q, busy_d;
  logic [7:0] rx_byte, load_byte;

  assign rx_byte   = {shreg_q, sda};
  assign load_byte = s_axis_tvalid ? s_axis_tdata : IDLE_BYTE;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    tx_d      = tx_q;
    rw_d      = rw_q;
    phase_d   = phase_q;
    sda_oe_d  = sda_oe_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    s_ready_d = 1'b0;
    busy_d    = busy_q;

    if (m_valid_q && m_axis_tready) begin
      m_valid_d = 1'b0;
    end

    if (!en_i) begin
      state_d  = StIdle;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_ev) begin
      state_d  = StAddr;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (stop_ev) begin
      state_d  = StIdle;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        StAddr: begin
          if (rise_ev) begin
            shreg_d = rx_byte[6:0];
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              rw_d    = sda;
              phase_d = 1'b0;
              if (shreg_q == TARGET_ADDR) begin
                state_d = StAddrAck;
                busy_d  = 1'b1;
              end else begin
                state_d = StWait;
              end
            end
          end
        end
        // phase_q=0: ACK not yet driven; 1: ACK held, release on this fall.
        StAddrAck, StWrAck: begin
          if (fall_ev) begin
            if (!phase_q) begin
              sda_oe_d = 1'b1;
              phase_d  = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              cnt_d    = '0;
              if (state_q == StAddrAck && rw_q) begin
                state_d   = StRdData;
                tx_d      = load_byte[6:0];
                sda_oe_d  = ~load_byte[7];
                s_ready_d = s_axis_tvalid;
              end else begin
                state_d = StWrData;
              end
            end
          end
        end
        StWrData: begin
          if (rise_ev) begin
            shreg_d = rx_byte[6:0];
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              if (!m_valid_q || m_axis_tready) begin
                m_data_d  = rx_byte;
                m_valid_d = 1'b1;
                state_d   = StWrAck;
                phase_d   = 1'b0;
              end else begin
                state_d = StWait;
              end
            end
          end
        end
        StRdData: begin
          if (rise_ev) begin
            cnt_d = cnt_q + 4'd1;
          end else if (fall_ev) begin
            if (cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              state_d  = StRdAck;
              phase_d  = 1'b0;
            end else begin
              sda_oe_d = ~tx_q[6];
              tx_d     = {tx_q[5:0], 1'b0};
            end
          end
        end
        // phase_q marks a master ACK seen on the rising edge.
        StRdAck: begin
          if (rise_ev) begin
            if (sda) begin
              state_d = StWait;
            end else begin
              phase_d = 1'b1;
            end
          end else if (fall_ev && phase_q) begin
            state_d   = StRdData;
            cnt_d     = '0;
            tx_d      = load_byte[6:0];
            sda_oe_d  = ~load_byte[7];
            s_ready_d = s_axis_tvalid;
          end
        end
        default: begin
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shreg_q   <= '0;
      tx_q      <= '0;
      rw_q      <= 1'b0;
      phase_q   <= 1'b0;
      sda_oe_q  <= 1'b0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
      rw_q      <= rw_d;
      phase_q   <= phase_d;
      sda_oe_q  <= sda_oe_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      s_ready_q <= s_ready_d;
      busy_q    <= busy_d;
    end
  end

  assign i2c_sda_io    = sda_oe_q ? 1'b0 : 1'bz;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tvalid = m_valid_q;
  assign s_axis_tready = s_ready_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_axis_i2c_target.sv
// Self-checking bench for axis_i2c_target: bit-level I2C master plus AXI-Stream models.
`timescale 1ns/1ps
module tb_axis_i2c_target;

  localparam int Q = 10;
`ifdef AXIS_I2C_TARGET_GLITCH_FILTER_EN
  localparam int LAT = 3 + 3;
`else
  localparam int LAT = 3;
`endif
  localparam logic [7:0] IDLE = 8'hFF;

  logic       clk_i = 1'b0;
  logic       arstn_i = 1'b0;
  logic       en_i = 1'b1;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  wire        sda_bus;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b1;
  logic [7:0] s_axis_tdata = 8'h00;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic       busy_o;

  assign sda_bus = m_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  axis_i2c_target dut (
    .clk_i         (clk_i),
    .arstn_i       (arstn_i),
    .en_i          (en_i),
    .i2c_scl_i     (scl),
    .i2c_sda_io    (sda_bus),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .busy_o        (busy_o)
  );

  initial forever #5 clk_i = ~clk_i;

  int compared = 0;
  int mismatched = 0;
  logic [7:0] got_q[$];
  logic [7:0] src_q[$];
  int pulses = 0;
  int drove = 0;
  int viol = 0;
  logic dut_drv = 1'b0;
  logic prev_drv = 1'b0;
  logic prev_m_low = 1'b0;

  // Stream sink/source and bus observer, all sampled on the falling clock edge.
  initial forever begin
    @(negedge clk_i);
    if (m_axis_tvalid && m_axis_tready) got_q.push_back(m_axis_tdata);
    if (s_axis_tready) begin
      pulses++;
      if (src_q.size() > 0) void'(src_q.pop_front());
    end
    s_axis_tvalid = (src_q.size() > 0);
    s_axis_tdata  = (src_q.size() > 0) ? src_q[0] : 8'h00;
    dut_drv = !m_low && (sda_bus === 1'b0);
    if (dut_drv) drove++;
    if (arstn_i && scl && !m_low && !prev_m_low && (dut_drv != prev_drv)) viol++;
    prev_drv   = dut_drv;
    prev_m_low = m_low;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic bus_start();
    m_low = 1'b0; tick(Q);
    scl = 1'b1;   tick(Q);
    m_low = 1'b1; tick(Q);
    scl = 1'b0;   tick(Q);
  endtask

  task automatic bus_stop(output logic b_before, output logic b_after);
    m_low = 1'b1; tick(Q);
    scl = 1'b1;   tick(Q);
    m_low = 1'b0;
    tick(LAT - 1);
    b_before = busy_o;
    tick(1);
    b_after = busy_o;
    tick(Q);
  endtask

  task automatic put_bit(input logic b);
    m_low = !b; tick(Q);
    scl = 1'b1; tick(2 * Q);
    scl = 1'b0; tick(Q);
  endtask

  task automatic get_bit(output logic b);
    m_low = 1'b0; tick(Q);
    scl = 1'b1;   tick(Q);
    b = sda_bus;  tick(Q);
    scl = 1'b0;   tick(Q);
  endtask

  task automatic put_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(ack);
  endtask

  task automatic get_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(nack);
  endtask

  task automatic test_reset();
    arstn_i = 1'b0;
    tick(4);
    compared++; if (m_axis_tvalid !== 1'b0) begin mismatched++;
      $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
    compared++; if (m_axis_tdata !== 8'h00) begin mismatched++;
      $display("FAIL reset_tdata: got %h want 00", m_axis_tdata); end
    compared++; if (s_axis_tready !== 1'b0) begin mismatched++;
      $display("FAIL reset_tready: got %b want 0", s_axis_tready); end
    compared++; if (busy_o !== 1'b0) begin mismatched++;
      $display("FAIL reset_busy: got %b want 0", busy_o); end
    compared++; if (sda_bus !== 1'b1) begin mismatched++;
      $display("FAIL reset_sda: got %b want 1", sda_bus); end
    arstn_i = 1'b1;
    tick(4);
  endtask

  task automatic test_write();
    logic ack, b0, b1;
    logic [7:0] exp_q[$];
    exp_q = '{8'hA5, 8'h3C};
    m_axis_tready = 1'b1; got_q.delete();
    bus_start();
    put_byte({7'h50, 1'b0}, ack);
    compared++; if (ack !== 1'b0) begin mismatched++;
      $display("FAIL wr_addr_ack: got %b want 0", ack); end
    compared++; if (busy_o !== 1'b1) begin mismatched++;
      $display("FAIL wr_busy: got %b want 1", busy_o); end
    foreach (exp_q[i]) begin
      put_byte(exp_q[i], ack);
      compared++; if (ack !== 1'b0) begin mismatched++;
        $display("FAIL wr_data_ack%0d: got %b want 0", i, ack); end
    end
    bus_stop(b0, b1);
    compared++; if ({b0, b1} !== 2'b10) begin mismatched++;
      $display("FAIL wr_busy_stop_latency: got %b%b want 10", b0, b1); end
    compared++; if (got_q.size() != exp_q.size()) begin mismatched++;
      $display("FAIL wr_beats: got %0d want %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      compared++; if (got_q[i] !== exp_q[i]) begin mismatched++;
        $display("FAIL wr_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_mismatch();
    logic ack, b0, b1;
    got_q.delete(); drove = 0;
    bus_start();
    put_byte({7'h51, 1'b0}, ack);
    compared++; if (ack !== 1'b1) begin mismatched++;
      $display("FAIL mm_addr_nack: got %b want 1", ack); end
    compared++; if (busy_o !== 1'b0) begin mismatched++;
      $display("FAIL mm_busy: got %b want 0", busy_o); end
    put_byte(8'h00, ack);
    compared++; if (ack !== 1'b1) begin mismatched++;
      $display("FAIL mm_data_nack: got %b want 1", ack); end
    bus_stop(b0, b1);
    compared++; if ({b0, b1} !== 2'b00) begin mismatched++;
      $display("FAIL mm_busy_stop: got %b%b want 00", b0, b1); end
    compared++; if (drove != 0) begin mismatched++;
      $display("FAIL mm_sda_driven: got %0d cycles want 0", drove); end
    compared++; if (got_q.size() != 0) begin mismatched++;
      $display("FAIL mm_beats: got %0d want 0", got_q.size()); end
  endtask

  task automatic test_hold();
    logic ack, b0, b1;
    got_q.delete(); m_axis_tready = 1'b0;
    bus_start();
    put_byte({7'h50, 1'b0}, ack);
    put_byte(8'hA5, ack);
    compared++; if (ack !== 1'b0) begin mismatched++;
      $display("FAIL hold_byte1_ack: got %b want 0", ack); end
    put_byte(8'h3C, ack);
    compared++; if (ack !== 1'b1) begin mismatched++;
      $display("FAIL hold_byte2_nack: got %b want 1", ack); end
    bus_stop(b0, b1);
    compared++; if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, 8'hA5}) begin mismatched++;
      $display("FAIL hold_reg: got %b/%h want 1/a5", m_axis_tvalid, m_axis_tdata); end
    m_axis_tready = 1'b1;
    tick(4);
    compared++; if (got_q.size() != 1) begin mismatched++;
      $display("FAIL hold_beats: got %0d want 1", got_q.size());
    end else begin
      compared++; if (got_q[0] !== 8'hA5) begin mismatched++;
        $display("FAIL hold_beat: got %h want a5", got_q[0]); end
    end
    compared++; if (m_axis_tvalid !== 1'b0) begin mismatched++;
      $display("FAIL hold_drain: got %b want 0", m_axis_tvalid); end
  endtask

  task automatic test_read();
    logic ack, b0, b1;
    logic [7:0] d;
    pulses = 0; src_q.delete(); src_q.push_back(8'h81);
    bus_start();
    put_byte({7'h50, 1'b1}, ack);
    compared++; if (ack !== 1'b0) begin mismatched++;
      $display("FAIL rd_addr_ack: got %b want 0", ack); end
    get_byte(d, 1'b0);
    compared++; if (d !== 8'h81) begin mismatched++;
      $display("FAIL rd_byte0: got %h want 81", d); end
    get_byte(d, 1'b1);
    compared++; if (d !== IDLE) begin mismatched++;
      $display("FAIL rd_byte1_idle: got %h want %h", d, IDLE); end
    tick(Q);
    compared++; if ({busy_o, sda_bus} !== 2'b11) begin mismatched++;
      $display("FAIL rd_wait_state: got busy/sda %b%b want 11", busy_o, sda_bus); end
    bus_stop(b0, b1);
    compared++; if ({b0, b1} !== 2'b10) begin mismatched++;
      $display("FAIL rd_busy_stop: got %b%b want 10", b0, b1); end
    compared++; if (pulses != 1) begin mismatched++;
      $display("FAIL rd_tready_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_repeated_start();
    logic ack, b0, b1;
    logic [7:0] w, r, d;
    w = 8'($urandom); r = 8'($urandom);
    got_q.delete(); src_q.delete(); pulses = 0; m_axis_tready = 1'b1;
    bus_start();
    put_byte({7'h50, 1'b0}, ack);
    put_byte(w, ack);
    compared++; if (ack !== 1'b0) begin mismatched++;
      $display("FAIL rs_wr_ack: got %b want 0", ack); end
    src_q.push_back(r);
    bus_start();
    put_byte({7'h50, 1'b1}, ack);
    compared++; if (ack !== 1'b0) begin mismatched++;
      $display("FAIL rs_readdr_ack: got %b want 0", ack); end
    get_byte(d, 1'b1);
    compared++; if (d !== r) begin mismatched++;
      $display("FAIL rs_rd_data: got %h want %h", d, r); end
    bus_stop(b0, b1);
    compared++; if (got_q.size() != 1 || got_q[0] !== w) begin mismatched++;
      $display("FAIL rs_wr_beat: got n=%0d want 1 beat %h", got_q.size(), w); end
  endtask

  task automatic test_reset_mid_ack();
    logic [7:0] a, w;
    logic ack, b0, b1;
    a = {7'h50, 1'b0}; w = 8'($urandom);
    bus_start();
    for (int i = 7; i >= 0; i--) put_bit(a[i]);
    m_low = 1'b0;
    tick(1);
    compared++; if (sda_bus !== 1'b0) begin mismatched++;
      $display("FAIL rm_ack_driven: got %b want 0", sda_bus); end
    arstn_i = 1'b0;
    tick(1);
    compared++; if (sda_bus !== 1'b1) begin mismatched++;
      $display("FAIL rm_sda_release: got %b want 1", sda_bus); end
    compared++; if ({busy_o, m_axis_tvalid, s_axis_tready, m_axis_tdata} !== 11'h0) begin
      mismatched++;
      $display("FAIL rm_outputs: got %b%b%b/%h want 000/00", busy_o, m_axis_tvalid,
               s_axis_tready, m_axis_tdata);
    end
    tick(2);
    arstn_i = 1'b1;
    scl = 1'b1; tick(2 * Q);
    scl = 1'b0; tick(Q);
    bus_stop(b0, b1);
    got_q.delete();
    bus_start();
    put_byte(a, ack);
    compared++; if (ack !== 1'b0) begin mismatched++;
      $display("FAIL rm_after_addr_ack: got %b want 0", ack); end
    put_byte(w, ack);
    bus_stop(b0, b1);
    compared++; if (got_q.size() != 1 || got_q[0] !== w) begin mismatched++;
      $display("FAIL rm_after_beat: got n=%0d want 1 beat %h", got_q.size(), w); end
  endtask

  // Reference: ACK iff address==0x50; writes deliver every byte in order;
  // reads return queued bytes first, then IDLE_BYTE, one tready pulse per queued byte used.
  task automatic test_random();
    logic [6:0] addr;
    logic rw, ack, b0, b1, match;
    logic [7:0] d, b;
    logic [7:0] exp_q[$];
    logic [7:0] model_q[$];
    int n, k;
    m_axis_tready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      addr = ($urandom_range(0, 1) == 1) ? 7'h50 : 7'($urandom_range(0, 127));
      if (addr == 7'h51) addr = 7'h52;
      if ($urandom_range(0, 2) == 0 && addr != 7'h50) addr = 7'h51;
      match = (addr == 7'h50);
      rw = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 3);
      k = $urandom_range(0, 2);
      got_q.delete(); exp_q.delete(); model_q.delete(); src_q.delete(); pulses = 0;
      if (match && rw) for (int j = 0; j < k; j++) begin
        b = 8'($urandom); model_q.push_back(b); src_q.push_back(b);
      end
      tick(2);
      bus_start();
      put_byte({addr, rw}, ack);
      compared++; if (ack !== !match) begin mismatched++;
        $display("FAIL rnd%0d_addr_ack: addr %h got %b want %b", t, addr, ack, !match); end
      if (match && !rw) begin
        for (int j = 0; j < n; j++) begin
          b = 8'($urandom); exp_q.push_back(b);
          put_byte(b, ack);
          compared++; if (ack !== 1'b0) begin mismatched++;
            $display("FAIL rnd%0d_wr_ack%0d: got %b want 0", t, j, ack); end
        end
      end else if (match && rw) begin
        for (int j = 0; j < n; j++) begin
          get_byte(d, (j == n - 1));
          b = (j < k) ? model_q[j] : IDLE;
          compared++; if (d !== b) begin mismatched++;
            $display("FAIL rnd%0d_rd%0d: got %h want %h", t, j, d, b); end
        end
      end
      bus_stop(b0, b1);
      compared++; if (got_q.size() != exp_q.size()) begin mismatched++;
        $display("FAIL rnd%0d_beats: got %0d want %0d", t, got_q.size(), exp_q.size());
      end else foreach (exp_q[j]) begin
        compared++; if (got_q[j] !== exp_q[j]) begin mismatched++;
          $display("FAIL rnd%0d_beat%0d: got %h want %h", t, j, got_q[j], exp_q[j]); end
      end
      compared++; if (pulses != ((match && rw) ? ((k < n) ? k : n) : 0)) begin mismatched++;
        $display("FAIL rnd%0d_pulses: got %0d want %0d", t, pulses,
                 (match && rw) ? ((k < n) ? k : n) : 0);
      end
      src_q.delete();
    end
  endtask

  task automatic test_contention();
    compared++; if (viol != 0) begin mismatched++;
      $display("FAIL sda_change_while_scl_high: got %0d events want 0", viol); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_mismatch();
    test_hold();
    test_read();
    test_repeated_start();
    test_reset_mid_ack();
    test_random();
    test_contention();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
